rc5_decrypt_core: RTL and testbench
===================================

Name: rc5_decrypt_core

Overview:
- Iterative RC5-16/r/16 decryption engine: 32-bit block (two 16-bit words), 128-bit key, 0–31 rounds.
- It is the inverse of the team's RC5 encrypt datapath. Ciphertext produced by the encrypt path under the same key and num_rounds returns the original plaintext.
- Runs key expansion internally on every request, then one decryption round per clock.
- Sits beside the encrypt engine under the accelerator top level.

Parameters:
- W, 16, word width in bits (fixed; block = 2*W).
- MAX_ROUNDS, 31, largest accepted num_rounds.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- decrypt  in  1  start request, sampled in IDLE only.
- num_rounds  in  5  round count r, not zero-indexed; r=0 means whitening only.
- key  in  128  secret key; byte k = key[8k+7:8k]; L[i] = key[16i+15:16i], i=0..7.
- d_in  in  32  ciphertext; A = d_in[15:0], B = d_in[31:16].
- d_out  out  32  plaintext; {B,A} packed the same way as d_in.
- done  out  1  one-cycle pulse; d_out is valid from this cycle onward.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst=0 at an edge forces IDLE; done=0, busy=0, d_out=0. Reset mid-operation aborts the operation; no done pulse is produced.
- Start: in IDLE, decrypt=1 at an edge latches key, num_rounds and d_in, and moves to INIT. decrypt is ignored in every other state; there is no queuing.
- Definitions: t = 2*(r+1); c = 8; all arithmetic is mod 2^16; rotate amount is the low 4 bits.
- INIT, t cycles: S[0]=P16=16'hB7E1, then S[i]=S[i-1]+Q16 (16'h9E37).
- MIX, 3*max(t,8) cycles:
  - Clear A, B, i, j on entry.
  - Each cycle: A=S[i]=rotl(S[i]+A+B,3); B=L[j]=rotl(L[j]+A+B,A+B); i=(i+1) mod t; j=(j+1) mod 8.
  - The updated A is used in B's computation within the same cycle.
- ROUND, r cycles, k=r down to 1:
  - B=rotr(B-S[2k+1],A)^A.
  - A=rotr(A-S[2k],B)^B, using the new B.
  - Skipped when r=0.
- WHITEN, 1 cycle: B=B-S[1]; A=A-S[0]; d_out registered.
- DONE, 1 cycle: done=1, then IDLE. d_out holds until the next completed operation or reset.
- Latency from the sampling edge to the first edge with done=1: t + 3*max(t,8) + r + 2.
  - r=12 gives 118 cycles.
  - r=0 gives 28 cycles.
- Storage: S as a 64x16 register array; L as an 8x16 array. Only entries 0..t-1 of S are used.
- No back-pressure: done is not acknowledged.
- Input changes after the start edge have no effect.

Decomposition:
- rc5_pkg holds:
  - W, P16, Q16, MAX_ROUNDS;
  - the state enum (IDLE, INIT, MIX, ROUND, WHITEN, DONE);
  - rotl16/rotr16 functions;
  - the block/word packing helpers.
- Sub-module rc5_key_expand implements INIT+MIX:
  - interface: start, num_rounds, key, S read port, ready;
  - shared with the encrypt core;
  - the decrypt core owns ROUND/WHITEN and the top FSM.

Test Plan:
- Round-trip, r=12: key=128'h0, plaintext 32'h0000_0000; the golden C model encrypts it; feed the ciphertext → d_out=32'h0000_0000, done high exactly once at cycle 118.
- Sweep r=1..31 and r=0: key=128'h0F0E..0100, plaintext 32'hDEAD_BEEF; golden-model ciphertext in → d_out=32'hDEAD_BEEF each time; latency matches the formula (r=0 → 28, r=31 → 289).
- Busy protection: assert decrypt again and change d_in/key mid-run → ignored; result equals that of the first request; busy high throughout.
- Reset mid-operation: rst=0 during MIX → next cycle busy=0, done=0, d_out=0. A new request then completes correctly, with no stale done pulse.
- Back-to-back: a second decrypt arriving the cycle after done → accepted in IDLE. The first d_out holds until the second operation's WHITEN.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5-16 definitions: word geometry, magic constants, FSM states and
// rotate/packing helpers used by the key expansion and decrypt datapaths.
package rc5_pkg;

    localparam int W          = 16;
    localparam int MAX_ROUNDS = 31;
    localparam int RND_W      = $clog2(MAX_ROUNDS + 1);
    localparam int S_DEPTH    = 64;
    localparam int L_DEPTH    = 8;
    localparam int KEY_W      = L_DEPTH * W;

    localparam logic [W-1:0] P16 = 16'hB7E1;
    localparam logic [W-1:0] Q16 = 16'h9E37;

    typedef logic [W-1:0]   word_t;
    typedef logic [2*W-1:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MIX,
        ROUND,
        WHITEN,
        DONE
    } state_t;

    // Rotates use only the low four bits of the amount, as RC5-16 requires.
    function automatic word_t rotl16(input word_t x, input word_t n);
        logic [2*W-1:0] tmp;
        tmp = {x, x} << n[3:0];
        return tmp[2*W-1:W];
    endfunction

    function automatic word_t rotr16(input word_t x, input word_t n);
        logic [2*W-1:0] tmp;
        tmp = {x, x} >> n[3:0];
        return tmp[W-1:0];
    endfunction

    function automatic word_t block_lo(input block_t blk);
        return blk[W-1:0];
    endfunction

    function automatic word_t block_hi(input block_t blk);
        return blk[2*W-1:W];
    endfunction

    function automatic block_t pack_block(input word_t hi, input word_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/rc5_key_expand.sv
// RC5-16 key schedule: fills S with the P/Q progression, then mixes the key
// words into it. Exposes a paired read port returning S[2k] and S[2k+1].
module rc5_key_expand
    import rc5_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RND_W-1:0] num_rounds,
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       pair_addr,
    output word_t            s_even,
    output word_t            s_odd,
    output logic             init_last,
    output logic             ready
);

    state_t     kstate;
    state_t     kstate_next;

    word_t      s_mem [S_DEPTH];
    word_t      l_mem [L_DEPTH];
    word_t      a_reg;
    word_t      b_reg;
    word_t      s_val;
    logic [6:0] t_len;
    logic [5:0] i_idx;
    logic [2:0] j_idx;
    logic [7:0] mix_cnt;
    logic [7:0] mix_last;

    logic [6:0] t_in;
    logic [7:0] mix_len_in;
    word_t      a_mix;
    word_t      ab_sum;
    word_t      b_mix;

    // Mix phase runs 3*max(t, c) steps with c = 8 key words.
    always_comb begin
        t_in       = {1'b0, num_rounds, 1'b0} + 7'd2;
        mix_len_in = (t_in < 7'd8) ? 8'd24 : ({1'b0, t_in} * 8'd3);
    end

    // The freshly rotated A feeds B's update in the same step.
    always_comb begin
        a_mix  = rotl16(s_mem[i_idx] + a_reg + b_reg, 16'd3);
        ab_sum = a_mix + b_reg;
        b_mix  = rotl16(l_mem[j_idx] + ab_sum, ab_sum);
    end

    always_comb begin
        init_last = (kstate == INIT) && ({1'b0, i_idx} == (t_len - 7'd1));
        ready     = (kstate == MIX) && (mix_cnt == mix_last);
        s_even    = s_mem[{pair_addr, 1'b0}];
        s_odd     = s_mem[{pair_addr, 1'b1}];
    end

    always_comb begin
        kstate_next = kstate;
        case (kstate)
            IDLE:    if (start)     kstate_next = INIT;
            INIT:    if (init_last) kstate_next = MIX;
            MIX:     if (ready)     kstate_next = IDLE;
            default:                kstate_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) kstate <= IDLE;
        else      kstate <= kstate_next;
    end

    always_ff @(posedge clk) begin
        case (kstate)
            IDLE: begin
                if (start) begin
                    t_len    <= t_in;
                    mix_last <= mix_len_in - 8'd1;
                    s_val    <= P16;
                    i_idx    <= '0;
                    for (int n = 0; n < L_DEPTH; n++) l_mem[n] <= key[W*n +: W];
                end
            end
            INIT: begin
                s_mem[i_idx] <= s_val;
                s_val        <= s_val + Q16;
                i_idx        <= i_idx + 6'd1;
                if (init_last) begin
                    i_idx   <= '0;
                    j_idx   <= '0;
                    a_reg   <= '0;
                    b_reg   <= '0;
                    mix_cnt <= '0;
                end
            end
            MIX: begin
                s_mem[i_idx] <= a_mix;
                l_mem[j_idx] <= b_mix;
                a_reg        <= a_mix;
                b_reg        <= b_mix;
                i_idx        <= ({1'b0, i_idx} == (t_len - 7'd1)) ? 6'd0 : (i_idx + 6'd1);
                j_idx        <= j_idx + 3'd1;
                mix_cnt      <= mix_cnt + 8'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc5_decrypt_core.sv
// Iterative RC5-16/r/16 decryption: key expansion via rc5_key_expand, then one
// inverse round per clock, final whitening, and a one-cycle done pulse.
module rc5_decrypt_core
    import rc5_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             decrypt,
    input  logic [RND_W-1:0] num_rounds,
    input  logic [KEY_W-1:0] key,
    input  logic [2*W-1:0]   d_in,
    output logic [2*W-1:0]   d_out,
    output logic             done,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [RND_W-1:0] kcnt;
    word_t            a_reg;
    word_t            b_reg;

    logic             kx_start;
    logic [4:0]       pair_addr;
    word_t            s_even;
    word_t            s_odd;
    logic             init_last;
    logic             ready;
    word_t            b_rnd;
    word_t            a_rnd;

    rc5_key_expand u_key_expand (
        .clk        (clk),
        .rst        (rst),
        .start      (kx_start),
        .num_rounds (num_rounds),
        .key        (key),
        .pair_addr  (pair_addr),
        .s_even     (s_even),
        .s_odd      (s_odd),
        .init_last  (init_last),
        .ready      (ready)
    );

    // Rounds walk k = r..1; whitening reads pair 0 (S[0], S[1]).
    always_comb begin
        kx_start  = (state == IDLE) && decrypt;
        pair_addr = (state == ROUND) ? kcnt : 5'd0;
        b_rnd     = rotr16(b_reg - s_odd, a_reg) ^ a_reg;
        a_rnd     = rotr16(a_reg - s_even, b_rnd) ^ b_rnd;
        done      = (state == DONE);
        busy      = (state != IDLE);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (decrypt)   state_next = INIT;
            INIT:   if (init_last) state_next = MIX;
            MIX:    if (ready)     state_next = (kcnt == '0) ? WHITEN : ROUND;
            ROUND:  if (kcnt == 5'd1) state_next = WHITEN;
            WHITEN:                state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && decrypt) begin
            a_reg <= block_lo(d_in);
            b_reg <= block_hi(d_in);
            kcnt  <= num_rounds;
        end else if (state == ROUND) begin
            a_reg <= a_rnd;
            b_reg <= b_rnd;
            kcnt  <= kcnt - 5'd1;
        end
    end

    // The result register is cleared by reset and otherwise holds between operations.
    always_ff @(posedge clk) begin
        if (!rst)                 d_out <= '0;
        else if (state == WHITEN) d_out <= pack_block(b_reg - s_odd, a_reg - s_even);
    end

endmodule

// File: tb/tb_rc5_decrypt_core.sv
// Bench for rc5_decrypt_core: a behavioural RC5-16 encrypt model produces
// ciphertexts; the core must return the plaintext with the expected latency.
module tb_rc5_decrypt_core;

    typedef logic [15:0] w16;

    typedef struct {
        logic [127:0] key;
        logic [4:0]   r;
        logic [31:0]  ct;
        logic [31:0]  exp_out;
        int           exp_lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         decrypt;
    logic [4:0]   num_rounds;
    logic [127:0] key;
    logic [31:0]  d_in;
    logic [31:0]  d_out;
    logic         done;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    w16 m_s [64];
    w16 m_l [8];

    localparam logic [127:0] KEY_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;

    rc5_decrypt_core dut (
        .clk        (clk),
        .rst        (rst),
        .decrypt    (decrypt),
        .num_rounds (num_rounds),
        .key        (key),
        .d_in       (d_in),
        .d_out      (d_out),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic w16 m_rotl(input w16 x, input w16 n);
        int sh;
        sh = int'(n[3:0]);
        if (sh == 0) return x;
        return (x << sh) | (x >> (16 - sh));
    endfunction

    // Reference RC5-16 key schedule with t = 2(r+1) and c = 8.
    task automatic model_expand(input logic [127:0] k, input int r);
        int t, i, j, steps;
        w16 a, b, sum;
        t = 2 * (r + 1);
        for (int q = 0; q < 8; q++) m_l[q] = k[16*q +: 16];
        m_s[0] = 16'hB7E1;
        for (int q = 1; q < t; q++) m_s[q] = m_s[q-1] + 16'h9E37;
        a = 0; b = 0; i = 0; j = 0;
        steps = 3 * ((t > 8) ? t : 8);
        for (int q = 0; q < steps; q++) begin
            sum    = m_s[i] + a + b;
            a      = m_rotl(sum, 16'd3);
            m_s[i] = a;
            sum    = a + b;
            sum    = m_rotl(m_l[j] + sum, sum);
            b      = sum;
            m_l[j] = b;
            i = (i + 1) % t;
            j = (j + 1) % 8;
        end
    endtask

    function automatic logic [31:0] model_encrypt(input logic [31:0] pt, input int r);
        w16 a, b;
        a = pt[15:0] + m_s[0];
        b = pt[31:16] + m_s[1];
        for (int i = 1; i <= r; i++) begin
            a = m_rotl(a ^ b, b) + m_s[2*i];
            b = m_rotl(b ^ a, a) + m_s[2*i+1];
        end
        return {b, a};
    endfunction

    function automatic int exp_latency(input int r);
        int t;
        t = 2 * (r + 1);
        return t + 3 * ((t > 8) ? t : 8) + r + 2;
    endfunction

    function automatic vec_t make_vec(input logic [127:0] k, input logic [31:0] pt, input int r);
        vec_t v;
        v.key     = k;
        v.r       = 5'(r);
        v.exp_out = pt;
        v.exp_lat = exp_latency(r);
        return v;
    endfunction

    // Drives a request so it is sampled at the next rising edge; returns mid-cycle 1.
    task automatic start_op(input logic [127:0] k, input logic [31:0] ct, input logic [4:0] r);
        @(negedge clk);
        key        = k;
        d_in       = ct;
        num_rounds = r;
        decrypt    = 1'b1;
        @(negedge clk);
        decrypt = 1'b0;
    endtask

    task automatic wait_done(input int lat_in, input bit hold_chk, input logic [31:0] hold_val,
                             output int lat, output int busy_drops, output int hold_bad);
        lat        = lat_in;
        busy_drops = 0;
        hold_bad   = 0;
        while (!done && lat < 400) begin
            if (!busy) busy_drops++;
            if (hold_chk && d_out !== hold_val) hold_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat, input int busy_drops);
        check({tag, "_dout"}, d_out, v.exp_out);
        check({tag, "_lat"}, lat, v.exp_lat);
        check({tag, "_busy"}, busy_drops, 0);
    endtask

    task automatic check_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_done_low"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    vec_t vecs [$];

    initial begin
        vec_t v, v2;
        int lat, bd, hb;
        logic [31:0] pt;

        rst = 1'b0; decrypt = 1'b0; num_rounds = '0; key = '0; d_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout", d_out, 32'h0);
        rst = 1'b1;

        vecs.push_back(make_vec(128'h0, 32'h0000_0000, 12));
        for (int r = 0; r < 32; r++) vecs.push_back(make_vec(KEY_SEQ, 32'hDEAD_BEEF, r));
        for (int n = 0; n < 6; n++)
            vecs.push_back(make_vec({$urandom, $urandom, $urandom, $urandom}, $urandom,
                                    int'($urandom_range(0, 31))));
        for (int n = 0; n < vecs.size(); n++) begin
            model_expand(vecs[n].key, int'(vecs[n].r));
            vecs[n].ct = model_encrypt(vecs[n].exp_out, int'(vecs[n].r));
        end

        for (int n = 0; n < vecs.size(); n++) begin
            start_op(vecs[n].key, vecs[n].ct, vecs[n].r);
            wait_done(1, 1'b0, 32'h0, lat, bd, hb);
            check_result($sformatf("vec%0d_r%0d", n, vecs[n].r), vecs[n], lat, bd);
            check_pulse_end($sformatf("vec%0d", n));
        end

        // Busy protection: new requests and input changes mid-run are ignored.
        v = make_vec(KEY_SEQ ^ 128'h1234, 32'hCAFE_F00D, 5);
        model_expand(v.key, 5);
        v.ct = model_encrypt(v.exp_out, 5);
        start_op(v.key, v.ct, v.r);
        lat = 1;
        bd  = 0;
        for (int n = 0; n < 10; n++) begin
            if (!busy) bd++;
            decrypt    = 1'b1;
            key        = ~v.key;
            d_in       = ~v.ct;
            num_rounds = 5'd20;
            @(negedge clk);
            lat++;
        end
        decrypt = 1'b0;
        begin
            int lat2, bd2;
            wait_done(lat, 1'b0, 32'h0, lat2, bd2, hb);
            check_result("busyprot", v, lat2, bd + bd2);
        end
        check_pulse_end("busyprot");

        // Reset during MIX aborts; the following request completes cleanly.
        v = make_vec(KEY_SEQ, 32'h1357_9BDF, 3);
        model_expand(v.key, 3);
        v.ct = model_encrypt(v.exp_out, 3);
        start_op(v.key, v.ct, v.r);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_dout", d_out, 32'h0);
        rst = 1'b1;
        v2 = make_vec(128'hA5A5_5A5A_0123_4567_89AB_CDEF_FEDC_BA98, 32'h2468_ACE0, 7);
        model_expand(v2.key, 7);
        v2.ct = model_encrypt(v2.exp_out, 7);
        start_op(v2.key, v2.ct, v2.r);
        wait_done(1, 1'b0, 32'h0, lat, bd, hb);
        check_result("after_rst", v2, lat, bd);
        check_pulse_end("after_rst");

        // Back-to-back: second request in the cycle after done; old d_out holds.
        v = make_vec(KEY_SEQ, 32'h0BAD_F00D, 2);
        model_expand(v.key, 2);
        v.ct = model_encrypt(v.exp_out, 2);
        start_op(v.key, v.ct, v.r);
        wait_done(1, 1'b0, 32'h0, lat, bd, hb);
        check_result("b2b_first", v, lat, bd);
        pt = v.exp_out;
        v2 = make_vec(KEY_SEQ, 32'h7777_1111, 4);
        model_expand(v2.key, 4);
        v2.ct = model_encrypt(v2.exp_out, 4);
        start_op(v2.key, v2.ct, v2.r);
        wait_done(1, 1'b1, pt, lat, bd, hb);
        check_result("b2b_second", v2, lat, bd);
        check("b2b_hold", hb, 0);
        check_pulse_end("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
